// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage feeding write-back
//
// Optional feature macro: MEM_TIMEOUT_EN (abort a memory access after
// TIMEOUT_CYCLES wait cycles without ack; default build waits forever).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  EX/MEM bundle handshake (ready only while IDLE)
//   in_op              00/11 ALU pass-through, 01 load, 10 store
//   in_addr/in_alu/in_sdata/in_dest/in_rf_we/in_pc  EX/MEM bundle fields
//   flush              squash the bundle being accepted or in flight
//   mem_req/mem_we/mem_addr/mem_wdata  data-memory request, held until ack
//   mem_rdata/mem_ack  data-memory response
//   wb_data            {error, pc, data, dest, valid, rf_we}
//   wb_valid           one-cycle pulse per completed bundle

module mem_access_stage #(
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DW-1:0]     in_addr,
  input  logic [DW-1:0]     in_alu,
  input  logic [DW-1:0]     in_sdata,
  input  logic [2:0]        in_dest,
  input  logic              in_rf_we,
  input  logic [DW-1:0]     in_pc,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ack,
  output logic [2*DW+5:0]   wb_data,
  output logic              wb_valid
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state;
  logic [2:0]    dest_q;
  logic          rf_we_q;
  logic [DW-1:0] pc_q;
  logic          flushed_q;   // a flush arrived earlier in this access
  logic          op_mem;
  logic          kill;
  logic          timeout;

  assign in_ready = (state == S_IDLE);
  assign op_mem   = (in_op == 2'b01) || (in_op == 2'b10);
  // A flush on the ack cycle itself applies to the completing bundle.
  assign kill     = flush | flushed_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  // Held at zero while IDLE, so it starts from zero on entry to WAIT_MEM.
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) begin
      to_cnt <= '0;
    end else if (!mem_ack) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // Ack has priority: timeout only fires on a cycle without ack.
  assign timeout = (state == S_WAIT) && !mem_ack &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_data   <= '0;
      wb_valid  <= 1'b0;
      dest_q    <= '0;
      rf_we_q   <= 1'b0;
      pc_q      <= '0;
      flushed_q <= 1'b0;
    end else begin
      // Pulse lasts one cycle; the bundle stays visible with its valid bit dropped.
      wb_valid   <= 1'b0;
      wb_data[1] <= 1'b0;
      if (state == S_IDLE) begin
        if (in_valid && !flush) begin
          if (!op_mem) begin
            wb_data  <= {1'b0, in_pc, in_alu, in_dest, 1'b1, in_rf_we};
            wb_valid <= 1'b1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= (in_op == 2'b10);
            mem_addr  <= in_addr;
            mem_wdata <= in_sdata;
            dest_q    <= in_dest;
            rf_we_q   <= in_rf_we;
            pc_q      <= in_pc;
            flushed_q <= 1'b0;
            state     <= S_WAIT;
          end
        end
      end else begin
        if (mem_ack) begin
          // Stores report their own data and never write the register file.
          wb_data   <= {1'b0, pc_q, (mem_we ? mem_wdata : mem_rdata), dest_q,
                        ~kill, rf_we_q & ~mem_we & ~kill};
          wb_valid  <= 1'b1;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          flushed_q <= 1'b0;
          state     <= S_IDLE;
        end else if (timeout) begin
          wb_data   <= {1'b1, pc_q, {DW{1'b0}}, dest_q, 1'b0, 1'b0};
          wb_valid  <= 1'b1;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          flushed_q <= 1'b0;
          state     <= S_IDLE;
        end else if (flush) begin
          flushed_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_addr, in_alu, in_sdata, in_pc;
  logic [2:0]  in_dest;
  logic        in_rf_we;
  logic        flush;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [37:0] wb_data;
  logic        wb_valid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DW(16), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_alu(in_alu), .in_sdata(in_sdata),
    .in_dest(in_dest), .in_rf_we(in_rf_we), .in_pc(in_pc), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_data(wb_data), .wb_valid(wb_valid)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] alu;
    logic [2:0]  dest;
    logic        rf_we;
    logic [15:0] pc;
    logic        fl;
    logic        exp_valid;
    logic [37:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = 2'b00; in_addr = '0; in_alu = '0; in_sdata = '0;
    in_dest = '0; in_rf_we = 1'b0; in_pc = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic issue_mem(input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] sdata, input logic [2:0] dest,
                           input logic [15:0] pc);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_sdata = sdata;
    in_dest = dest; in_rf_we = 1'b1; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'b00, 16'h1234, 3'd5, 1'b1, 16'h0100, 1'b0, 1'b1,
                {1'b0, 16'h0100, 16'h1234, 3'd5, 1'b1, 1'b1}};
    vecs[1] = '{2'b00, 16'hFFFF, 3'd7, 1'b0, 16'hFFFE, 1'b0, 1'b1,
                {1'b0, 16'hFFFE, 16'hFFFF, 3'd7, 1'b1, 1'b0}};
    vecs[2] = '{2'b11, 16'h0001, 3'd0, 1'b1, 16'h0002, 1'b0, 1'b1,
                {1'b0, 16'h0002, 16'h0001, 3'd0, 1'b1, 1'b1}};
    vecs[3] = '{2'b00, 16'h5555, 3'd1, 1'b1, 16'h0004, 1'b1, 1'b0, 38'h0};
    vecs[4] = '{2'b00, 16'hA5A5, 3'd3, 1'b1, 16'h0010, 1'b0, 1'b1,
                {1'b0, 16'h0010, 16'hA5A5, 3'd3, 1'b1, 1'b1}};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst mem_req", 64'(mem_req), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst wb_data", 64'(wb_data), 64'd0);
    check("rst wb_valid", 64'(wb_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);

    // Back-to-back pass-through bundles, one per cycle.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_alu = vecs[i].alu;
      in_dest = vecs[i].dest; in_rf_we = vecs[i].rf_we; in_pc = vecs[i].pc;
      flush = vecs[i].fl;
      check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
      tick();
      check($sformatf("v%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("v%0d wb_data", i), 64'(wb_data), 64'(vecs[i].exp_data));
      check($sformatf("v%0d mem_req", i), 64'(mem_req), 64'd0);
    end
    idle_inputs();
    tick();
    check("pass valid bit cleared", 64'(wb_data[1]), 64'd0);
    check("pass data held", 64'(wb_data[20:5]), 64'hA5A5);

    // Load, ack after 3 wait cycles.
    issue_mem(2'b01, 16'h0040, 16'h0000, 3'd2, 16'h0200);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ld req c%0d", i), 64'(mem_req), 64'd1);
      check($sformatf("ld addr c%0d", i), 64'(mem_addr), 64'h0040);
      check($sformatf("ld ready c%0d", i), 64'(in_ready), 64'd0);
      check($sformatf("ld we c%0d", i), 64'(mem_we), 64'd0);
      check($sformatf("ld wbv c%0d", i), 64'(wb_valid), 64'd0);
      mem_ack = (i == 3); mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000;
      tick();
    end
    mem_ack = 1'b0;
    check("ld done req", 64'(mem_req), 64'd0);
    check("ld wb_valid", 64'(wb_valid), 64'd1);
    check("ld wb_data", 64'(wb_data), 64'({1'b0, 16'h0200, 16'hBEEF, 3'd2, 1'b1, 1'b1}));
    check("ld ready after", 64'(in_ready), 64'd1);
    tick();
    check("ld single pulse", 64'(wb_valid), 64'd0);
    check("ld valid bit cleared", 64'(wb_data[1]), 64'd0);

    // Store, ack in the first request cycle.
    issue_mem(2'b10, 16'h0010, 16'h00AA, 3'd4, 16'h0300);
    check("st req", 64'(mem_req), 64'd1);
    check("st we", 64'(mem_we), 64'd1);
    check("st wdata", 64'(mem_wdata), 64'h00AA);
    check("st addr", 64'(mem_addr), 64'h0010);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    check("st wb_valid", 64'(wb_valid), 64'd1);
    check("st wb_data", 64'(wb_data), 64'({1'b0, 16'h0300, 16'h00AA, 3'd4, 1'b1, 1'b0}));
    tick();

    // Load flushed during WAIT_MEM still completes, marked invalid.
    issue_mem(2'b01, 16'h0050, 16'h0000, 3'd6, 16'h0400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl req held", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("fl wb_valid", 64'(wb_valid), 64'd1);
    check("fl wb_data", 64'(wb_data), 64'({1'b0, 16'h0400, 16'h1111, 3'd6, 1'b0, 1'b0}));
    tick();

    // Flush on the ack cycle applies to the completing bundle.
    issue_mem(2'b01, 16'h0060, 16'h0000, 3'd1, 16'h0500);
    mem_ack = 1'b1; mem_rdata = 16'h2222; flush = 1'b1;
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    check("fla wb_valid", 64'(wb_valid), 64'd1);
    check("fla wb_data", 64'(wb_data), 64'({1'b0, 16'h0500, 16'h2222, 3'd1, 1'b0, 1'b0}));
    tick();

    // Reset mid-WAIT_MEM aborts with no pulse; a late ack is ignored.
    issue_mem(2'b01, 16'h0070, 16'h0000, 3'd2, 16'h0600);
    check("rw req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw req dropped", 64'(mem_req), 64'd0);
    check("rw no pulse", 64'(wb_valid), 64'd0);
    check("rw ready", 64'(in_ready), 64'd1);
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    check("idle ack ignored", 64'(wb_valid), 64'd0);
    check("idle ack no req", 64'(mem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
    issue_mem(2'b01, 16'h0080, 16'h0000, 3'd3, 16'h0700);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to req c%0d", i), 64'(mem_req), 64'd1);
      tick();
    end
    check("to req dropped", 64'(mem_req), 64'd0);
    check("to wb_valid", 64'(wb_valid), 64'd1);
    check("to error bit", 64'(wb_data[37]), 64'd1);
    check("to flags", 64'(wb_data[1:0]), 64'd0);
    check("to ready", 64'(in_ready), 64'd1);
    tick();
    check("to single pulse", 64'(wb_valid), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
